seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Multiplexed scan driver for a NUM_DIGITS common-anode seven-segment display, downstream of the single-digit hex decode stage.
- Captures a multi-nibble result word from the datapath and holds it in a double-buffered register.
- Time-multiplexes the digits at a divided refresh rate, with anti-ghosting blanking and optional leading-zero suppression.
- Drives active-low segment, decimal-point and anode pins directly.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clk cycles each digit stays selected (>= BLANK_CYC+2)
BLANK_CYC, 64, cycles at the start of each digit slot with all anodes off

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
value  in  4*NUM_DIGITS  hex word; nibble k is shown on digit k (digit 0 = least significant)
load  in  1  single-cycle strobe; captures value and dp_in
dp_in  in  NUM_DIGITS  decimal-point enables, captured with load
lz_en  in  1  leading-zero suppression enable (live, not captured)
seg  out  7  segments g..a, active-low
dp  out  1  decimal point, active-low
an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-high
frame_tick  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Reset (rst low, asynchronous): div_cnt=0, idx=0, pend_reg=0, pend_valid=0, disp_reg=0, disp_dp=0.
- Outputs during reset: an=all 1, seg=7'h7F, dp=1, frame_tick=0.
- Reset asserted mid-scan forces this state immediately.
- After reset release, scanning starts at digit 0, showing "0" (lz_en suppresses digits 1..N-1).
- div_cnt counts 0..REFRESH_DIV-1 and then wraps.
- Slot end (div_cnt==REFRESH_DIV-1):
  - div_cnt goes to 0.
  - idx increments, wrapping from NUM_DIGITS-1 to 0.
  - frame_tick pulses in the same cycle as the idx wrap to 0.
- Double buffer:
  - load=1 writes value/dp_in into pend_reg and sets pend_valid.
  - At the frame boundary (the slot-end cycle where idx wraps to 0) with pend_valid=1: disp_reg <= pend_reg and pend_valid cleared. The displayed word never changes mid-frame.
  - load coincident with the frame boundary: the incoming value goes straight into disp_reg and pend_valid ends at 0.
  - Back-to-back loads: the last one wins.
- Blanking: while div_cnt < BLANK_CYC, an=all 1 and seg/dp are don't-care, driven 7'h7F/1.
- Otherwise an has bit idx low and all other bits high.
- Decode encoding (active-low, bit0=a … bit6=g):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- Leading-zero suppression (lz_en=1):
  - Digit k is blanked (seg=7'h7F, dp=1, anode still driven) if all nibbles k..NUM_DIGITS-1 of disp_reg are zero and k>0.
  - Digit 0 is never suppressed.
  - A digit whose disp_dp bit is set is never suppressed.
- dp = ~disp_dp[idx] when the digit is not blanked.
- Latency: seg/dp/an are all registered and update one cycle after the div_cnt/idx state that selects them. frame_tick is registered with the same one-cycle alignment.
- Width rules:
  - div_cnt is $clog2(REFRESH_DIV) bits.
  - idx is max(1,$clog2(NUM_DIGITS)) bits.
  - No arithmetic on value; nibbles are selected by idx.

Decomposition:
- Shared package seg_pkg:
  - typedef seg7_t (logic [6:0]).
  - Constants SEG_BLANK=7'h7F and the 16-entry hex pattern table.
  - Pure function hex_to_seg7(nibble) returning seg7_t.
- Sub-module seg_refresh_timer:
  - Holds div_cnt and idx.
  - Outputs idx, blank, slot_end and frame_wrap.
- The top level holds the buffers, suppression logic, and registered outputs.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2):
- Reset check: hold rst low 5 cycles then release -> an=4'hF, seg=7F, dp=1 during reset. First unblanked slot: an=4'hE, seg=40.
- Full scan: load value=16'h1A3F, lz_en=0 -> after the next frame boundary, slots show digit0 seg=0E, digit1 seg=30, digit2 seg=08, digit3 seg=79. an sequence E,D,B,7. Each slot's first 2 cycles have an=F. frame_tick pulses once per 32 cycles.
- Tear-free update: load 16'h0005 mid-frame while showing 16'h1A3F -> remaining slots of the current frame still show 1A3F, and 0005 appears only from the next digit 0.
- Coincident load: assert load exactly on the frame-boundary cycle with 16'h2222 -> the next frame shows 2222 and pend_valid=0.
- Leading zeros: value=16'h0040, dp_in=4'b1000, lz_en=1 -> digit3 shows seg=40 with dp=0 (dp overrides suppression), digit2 shows seg=40 (not suppressed, since a higher digit is kept), digit1 shows seg=19, digit0 shows 40. Then value=16'h0000 with dp_in=0 -> only digit 0 is lit (seg=40), digits 1-3 show seg=7F.
- Reset mid-scan: pull rst low asynchronously during digit-2 display -> outputs go to reset values within the same cycle. After release, the scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment type,
// blank pattern and the hex-digit segment table (active-low, bit0=a .. bit6=g).
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    localparam seg7_t HEX_SEG7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Pure lookup of the active-low segment pattern for one hex nibble.
    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        return HEX_SEG7[nibble];
    endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Slot timer for the digit scan: divides clk into REFRESH_DIV-cycle slots,
// steps the digit index each slot and flags the anti-ghosting blank window.
module seg_refresh_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 64,
    parameter int IDX_W       = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             blank,
    output logic             slot_end,
    output logic             frame_wrap
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign slot_end   = (div_cnt_q == DIV_LAST);
    assign frame_wrap = slot_end & (idx_q == IDX_LAST);
    assign blank      = (div_cnt_q < BLANK_END);
    assign idx        = idx_q;

    // Next-state: count within the slot, advance the digit on slot end.
    always_comb begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (slot_end) begin
            div_cnt_d = {CNT_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Timer state flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= {CNT_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver: double-buffered
// display word, frame-aligned updates, leading-zero suppression and
// registered active-low segment/dp/anode outputs.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IDX_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int WORD_W = 4 * NUM_DIGITS;

    logic [IDX_W-1:0]      idx_s;
    logic                  blank_s;
    logic                  slot_end_s;
    logic                  frame_wrap_s;
    logic                  boundary_s;
    logic [3:0]            nib_s;
    logic [NUM_DIGITS-1:0] supp_s;
    logic                  run_s;

    logic [WORD_W-1:0]     pend_reg_q, pend_reg_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [WORD_W-1:0]     disp_reg_q, disp_reg_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    seg7_t                 seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    seg_refresh_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx_s),
        .blank      (blank_s),
        .slot_end   (slot_end_s),
        .frame_wrap (frame_wrap_s)
    );

    // The displayed word may only change on the last slot-end of a frame.
    assign boundary_s = slot_end_s & frame_wrap_s;

    // Double buffer: loads land in pending, pending moves to display at the frame boundary.
    always_comb begin
        pend_reg_d   = pend_reg_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_reg_d   = disp_reg_q;
        disp_dp_d    = disp_dp_q;
        if (load) begin
            pend_reg_d = value;
            pend_dp_d  = dp_in;
        end else begin
            pend_reg_d = pend_reg_q;
        end
        if (boundary_s) begin
            // A load on the boundary cycle is newer than anything pending.
            if (load) begin
                disp_reg_d = value;
                disp_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                disp_reg_d = pend_reg_q;
                disp_dp_d  = pend_dp_q;
            end else begin
                disp_reg_d = disp_reg_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Suppression chain from the top digit down: a digit is dropped only if it
    // and every digit above it are zero with no decimal point lit.
    always_comb begin
        supp_s = {NUM_DIGITS{1'b0}};
        run_s  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run_s     = run_s & (disp_reg_q[4*k +: 4] == 4'h0) & ~disp_dp_q[k];
            supp_s[k] = run_s & (k != 0);
        end
    end

    assign nib_s = disp_reg_q[{idx_s, 2'b00} +: 4];

    // Output pattern for the currently selected digit, registered below.
    always_comb begin
        an_d         = {NUM_DIGITS{1'b1}};
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        frame_tick_d = frame_wrap_s;
        if (!blank_s) begin
            an_d[idx_s] = 1'b0;
            if (lz_en && supp_s[idx_s]) begin
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end else begin
                seg_d = hex_to_seg7(nib_s);
                dp_d  = ~disp_dp_q[idx_s];
            end
        end else begin
            an_d = {NUM_DIGITS{1'b1}};
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg_q   <= {WORD_W{1'b0}};
            pend_dp_q    <= {NUM_DIGITS{1'b0}};
            pend_valid_q <= 1'b0;
            disp_reg_q   <= {WORD_W{1'b0}};
            disp_dp_q    <= {NUM_DIGITS{1'b0}};
        end else begin
            pend_reg_q   <= pend_reg_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_reg_q   <= disp_reg_d;
            disp_dp_q    <= disp_dp_d;
        end
    end

    // Pin registers; reset leaves every pin in its inactive (high) state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= {NUM_DIGITS{1'b1}};
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, 8-cycle slots, 2 blank cycles).
// A cycle-count reference model predicts every output each cycle; directed
// steps add fixed expectations for the documented scenarios.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = N * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: s counts clock edges since reset release.
    int          s;
    int          ft_cnt;
    logic [15:0] shown, pend;
    logic [3:0]  shown_dp, pend_dp;
    logic        pv;
    logic [6:0]  tbl [16];
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_ft;

    logic [3:0]  an_seq   [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0]  scan_seg [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};
    logic [6:0]  lz1_seg  [4] = '{7'h40, 7'h19, 7'h40, 7'h40};
    logic        lz1_dp   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0]  lz2_seg  [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s = 0; shown = 16'h0; shown_dp = 4'h0; pend = 16'h0; pend_dp = 4'h0; pv = 1'b0;
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_an"},  16'(an),         16'hF);
        chk({tag, "_seg"}, 16'(seg),        16'h7F);
        chk({tag, "_dp"},  16'(dp),         16'h1);
        chk({tag, "_ft"},  16'(frame_tick), 16'h0);
    endtask

    // One clock: predict outputs from the pre-edge model state, advance model, compare.
    task automatic cycle(input logic ld);
        int   ph, dg, msd;
        logic sup, boundary;
        load = ld;
        @(posedge clk);
        ph  = s % RD;
        dg  = (s / RD) % N;
        msd = 0;
        for (int j = 0; j < N; j++) begin
            if (shown[4*j +: 4] != 4'h0 || shown_dp[j]) msd = j;
        end
        sup = lz_en && (dg > msd);
        if (ph < BC) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = ~(4'b0001 << dg);
            e_seg = sup ? 7'h7F : tbl[shown[4*dg +: 4]];
            e_dp  = sup ? 1'b1 : ~shown_dp[dg];
        end
        boundary = ((s % FR) == FR - 1);
        e_ft = boundary;
        if (boundary && pv) begin
            shown = pend; shown_dp = pend_dp; pv = 1'b0;
        end
        if (ld) begin
            pend = value; pend_dp = dp_in;
            if (boundary) begin
                shown = value; shown_dp = dp_in;
            end else begin
                pv = 1'b1;
            end
        end
        s++;
        @(negedge clk);
        chk("an",  16'(an),         16'(e_an));
        chk("seg", 16'(seg),        16'(e_seg));
        chk("dp",  16'(dp),         16'(e_dp));
        chk("ft",  16'(frame_tick), 16'(e_ft));
        ft_cnt += int'(frame_tick);
        load = 1'b0;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (s != target && guard < 4000) begin
            cycle(1'b0);
            guard++;
        end
        if (s != target) begin
            tests++; fails++;
            $error("FAIL run_to: observed %0d expected %0d", s, target);
        end
    endtask

    function automatic int next_frame();
        return s - (s % FR) + FR;
    endfunction

    initial begin
        int  b;
        logic ld;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0; lz_en = 1'b0; ft_cnt = 0;
        model_reset();

        // Reset held for 5 cycles.
        repeat (5) begin
            @(negedge clk);
            chk_reset_pins("rst");
        end
        rst = 1'b1;
        repeat (3) cycle(1'b0);
        chk("first_an",  16'(an),  16'hE);
        chk("first_seg", 16'(seg), 16'h40);

        // Full scan of 1A3F.
        value = 16'h1A3F; dp_in = 4'h0;
        cycle(1'b1);
        b = next_frame();
        run_to(b);
        ft_cnt = 0;
        for (int k = 0; k < N; k++) begin
            run_to(b + RD*k + 1);
            chk("scan_blank_an", 16'(an), 16'hF);
            run_to(b + RD*k + 3);
            chk("scan_an",  16'(an),  16'(an_seq[k]));
            chk("scan_seg", 16'(seg), 16'(scan_seg[k]));
        end
        run_to(b + 2*FR);
        chk("ft_count", 16'(ft_cnt), 16'd2);

        // Tear-free update: load mid-frame.
        b = s;
        run_to(b + 12);
        value = 16'h0005;
        cycle(1'b1);
        run_to(b + RD*2 + 3);
        chk("tear_d2", 16'(seg), 16'h08);
        run_to(b + RD*3 + 3);
        chk("tear_d3", 16'(seg), 16'h79);
        run_to(b + FR + 3);
        chk("new_d0", 16'(seg), 16'h12);
        run_to(b + FR + RD + 3);
        chk("new_d1", 16'(seg), 16'h40);

        // Load coincident with the frame boundary.
        b = next_frame();
        run_to(b - 1);
        value = 16'h2222;
        cycle(1'b1);
        chk("coinc_pv", 16'(dut.pend_valid_q), 16'h0);
        run_to(b + 3);
        chk("coinc_d0", 16'(seg), 16'h24);
        run_to(b + RD*3 + 3);
        chk("coinc_d3", 16'(seg), 16'h24);

        // Leading-zero suppression.
        lz_en = 1'b1; value = 16'h0040; dp_in = 4'b1000;
        cycle(1'b1);
        b = next_frame();
        for (int k = 0; k < N; k++) begin
            run_to(b + RD*k + 3);
            chk("lz1_seg", 16'(seg), 16'(lz1_seg[k]));
            chk("lz1_dp",  16'(dp),  16'(lz1_dp[k]));
        end
        value = 16'h0000; dp_in = 4'h0;
        cycle(1'b1);
        b = next_frame();
        for (int k = 0; k < N; k++) begin
            run_to(b + RD*k + 3);
            chk("lz2_seg", 16'(seg), 16'(lz2_seg[k]));
            chk("lz2_an",  16'(an),  16'(an_seq[k]));
        end

        // Random loads, dp patterns and lz_en toggles against the model.
        repeat (800) begin
            ld = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dp_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                ld    = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
            cycle(ld);
        end

        // Asynchronous reset during digit 2.
        b = next_frame();
        run_to(b + RD*2 + 4);
        chk("pre_rst_an", 16'(an), 16'hB);
        #2 rst = 1'b0;
        #1 chk_reset_pins("async_rst");
        repeat (2) @(negedge clk);
        chk_reset_pins("rst_hold");
        rst = 1'b1; lz_en = 1'b1;
        model_reset();
        repeat (3) cycle(1'b0);
        chk("restart_an",  16'(an),  16'hE);
        chk("restart_seg", 16'(seg), 16'h40);
        run_to(RD + 3);
        chk("restart_d1_seg", 16'(seg), 16'h7F);
        chk("restart_d1_an",  16'(an),  16'hD);
        run_to(2 * FR);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
